reg_file_wb: RTL and testbench

Register file and writeback stage that receives EX-stage write traffic (ALU or ID data, destination register, write enable, flag updates) and serves the two operand read ports back to EX. It holds eight 32-bit general registers plus the CPSR flag register. Writes pass through a one-entry writeback stage before they commit, and reads are bypassed from that stage so EX always sees the newest value.

---
 rtl/reg_file_wb.sv | 62 ++++++
 tb/tb_reg_file_wb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// Eight-entry register file with CPSR, fed through a one-entry writeback stage; reads bypass that stage.
// Read latency 0 (combinational); a write is visible from the cycle after capture; one write per cycle, no backpressure.
module reg_file_wb #(
    parameter int NREGS = 8,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_enable,
    input  logic             w_select,
    input  logic [WIDTH-1:0] w_alu,
    input  logic [WIDTH-1:0] w_id,
    input  logic [AW-1:0]    w_addr,
    input  logic             flags_we,
    input  logic [3:0]       flags_in,
    input  logic [AW-1:0]    r_addr_0,
    input  logic [AW-1:0]    r_addr_1,
    output logic [WIDTH-1:0] r_val_0,
    output logic [WIDTH-1:0] r_val_1,
    output logic [3:0]       cpsr_flags,
    output logic             wb_pending
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       cpsr;

    // Capture and commit share one edge: the array takes the old stage
    // contents while the stage takes the new write, so later writes win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            cpsr     <= 4'd0;
        end else begin
            wb_valid <= w_enable;
            if (w_enable) begin
                wb_addr <= w_addr;
                wb_data <= w_select ? w_id : w_alu;
            end
            if (wb_valid) begin
                regs[wb_addr] <= wb_data;
            end
            if (flags_we) begin
                cpsr <= flags_in;
            end
        end
    end

    assign r_val_0    = (wb_valid && (r_addr_0 == wb_addr)) ? wb_data : regs[r_addr_0];
    assign r_val_1    = (wb_valid && (r_addr_1 == wb_addr)) ? wb_data : regs[r_addr_1];
    assign cpsr_flags = cpsr;
    assign wb_pending = wb_valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized and directed bench for reg_file_wb against an architectural-visibility model.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_enable, w_select, flags_we;
    logic [31:0] w_alu, w_id;
    logic [2:0]  w_addr, r_addr_0, r_addr_1;
    logic [3:0]  flags_in;
    logic [31:0] r_val_0, r_val_1;
    logic [3:0]  cpsr_flags;
    logic        wb_pending;

    int total = 0;
    int bad   = 0;

    // Model: the value a read should see, i.e. the newest write captured so far.
    logic [31:0] vis [8];
    logic        m_pend;
    logic [3:0]  m_cpsr;

    reg_file_wb dut (
        .clk(clk), .rst_n(rst_n),
        .w_enable(w_enable), .w_select(w_select), .w_alu(w_alu), .w_id(w_id),
        .w_addr(w_addr), .flags_we(flags_we), .flags_in(flags_in),
        .r_addr_0(r_addr_0), .r_addr_1(r_addr_1),
        .r_val_0(r_val_0), .r_val_1(r_val_1),
        .cpsr_flags(cpsr_flags), .wb_pending(wb_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) vis[i] = '0;
        m_pend = 1'b0;
        m_cpsr = 4'd0;
    endtask

    // Advance one edge, fold the sampled inputs into the model, then settle.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (w_enable) vis[w_addr] = w_select ? w_id : w_alu;
            m_pend = w_enable;
            if (flags_we) m_cpsr = flags_in;
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic sel, input logic [31:0] alu, input logic [31:0] id);
        w_enable = 1'b1; w_addr = a; w_select = sel; w_alu = alu; w_id = id;
    endtask

    task automatic idle();
        w_enable = 1'b0; flags_we = 1'b0;
        w_alu = $urandom; w_id = $urandom; w_addr = 3'($urandom);
    endtask

    task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
        r_addr_0 = a0; r_addr_1 = a1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        w_enable = 0; w_select = 0; w_alu = 0; w_id = 0; w_addr = 0;
        flags_we = 0; flags_in = 0; r_addr_0 = 0; r_addr_1 = 0;
        model_reset();
        tick(); tick();
        rd(3'd3, 3'd6);
        chk("rst_rval0", r_val_0, 32'h0);
        chk("rst_rval1", r_val_1, 32'h0);
        chk("rst_pend", {31'd0, wb_pending}, 32'h0);
        chk("rst_cpsr", {28'd0, cpsr_flags}, 32'h0);

        // Reset while a write sits in the stage: it must never commit.
        #2 rst_n = 1'b1;
        wr(3'd3, 1'b0, 32'hDEADBEEF, 32'h0);
        flags_we = 1'b1; flags_in = 4'hF;
        tick();
        rd(3'd3, 3'd3);
        chk("midwr_pend_before", {31'd0, wb_pending}, 32'h1);
        rst_n = 1'b0;
        idle();
        #1;
        chk("midwr_rval0_inrst", r_val_0, 32'h0);
        chk("midwr_pend_inrst", {31'd0, wb_pending}, 32'h0);
        chk("midwr_cpsr_inrst", {28'd0, cpsr_flags}, 32'h0);
        tick();
        #2 rst_n = 1'b1;
        tick(); tick();
        rd(3'd3, 3'd3);
        chk("midwr_rval0_after", r_val_0, 32'h0);
        chk("midwr_pend_after", {31'd0, wb_pending}, 32'h0);
        chk("midwr_cpsr_after", {28'd0, cpsr_flags}, 32'h0);

        // Write, bypass, commit; w_select picks w_id.
        wr(3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234);
        tick();
        idle();
        rd(3'd0, 3'd5);
        chk("byp_c1_val", r_val_1, 32'h1234);
        chk("byp_c1_pend", {31'd0, wb_pending}, 32'h1);
        tick();
        rd(3'd0, 3'd5);
        chk("byp_c2_val", r_val_1, 32'h1234);
        chk("byp_c2_pend", {31'd0, wb_pending}, 32'h0);

        // Back-to-back writes to R2.
        wr(3'd2, 1'b0, 32'h11, 32'h0);
        tick();
        wr(3'd2, 1'b0, 32'h22, 32'h0);
        rd(3'd2, 3'd4);
        chk("b2b_c1", r_val_0, 32'h11);
        for (int c = 2; c < 6; c++) begin
            tick();
            idle();
            rd(3'd2, 3'd2);
            chk($sformatf("b2b_c%0d", c), r_val_0, 32'h22);
        end

        // Both ports on the same committed register.
        wr(3'd7, 1'b0, 32'h8000_0000, 32'h0);
        tick(); idle(); tick(); tick();
        rd(3'd7, 3'd7);
        chk("dual_p0", r_val_0, 32'h8000_0000);
        chk("dual_p1", r_val_1, 32'h8000_0000);

        // Flags alongside a register write, then a hold.
        wr(3'd1, 1'b0, 32'h0000_0ABC, 32'h0);
        flags_we = 1'b1; flags_in = 4'b1010;
        tick();
        idle(); flags_in = 4'b0101;
        rd(3'd1, 3'd1);
        chk("flags_set", {28'd0, cpsr_flags}, 32'hA);
        chk("flags_r1", r_val_0, 32'h0000_0ABC);
        tick();
        rd(3'd1, 3'd1);
        chk("flags_hold", {28'd0, cpsr_flags}, 32'hA);

        // Full sweep, alternating the data source.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) wr(3'(i), 1'b0, 32'(8 * i + 1), 32'hBAD0_0000);
            else            wr(3'(i), 1'b1, 32'hBAD1_0000, 32'(8 * i + 1));
            tick();
        end
        idle(); tick(); tick();
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(7 - i));
            chk($sformatf("sweep_p0_r%0d", i), r_val_0, 32'(8 * i + 1));
            chk($sformatf("sweep_p1_r%0d", 7 - i), r_val_1, 32'(8 * (7 - i) + 1));
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            w_enable = ($urandom_range(0, 3) != 0);
            w_select = 1'($urandom);
            w_alu    = $urandom;
            w_id     = $urandom;
            w_addr   = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom);
            flags_we = 1'($urandom);
            flags_in = 4'($urandom);
            tick();
            w_alu = $urandom; w_id = $urandom; w_addr = 3'($urandom);
            rd(3'($urandom), 3'($urandom));
            chk($sformatf("rnd%0d_p0", n), r_val_0, vis[r_addr_0]);
            chk($sformatf("rnd%0d_p1", n), r_val_1, vis[r_addr_1]);
            chk($sformatf("rnd%0d_pend", n), {31'd0, wb_pending}, {31'd0, m_pend});
            chk($sformatf("rnd%0d_cpsr", n), {28'd0, cpsr_flags}, {28'd0, m_cpsr});
        end

        idle(); tick(); tick();
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(i));
            chk($sformatf("final_r%0d", i), r_val_0, vis[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
